lab5_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the 16-bit instruction ROM. Holds the PC, drives the

---
 rtl/lab5_fetch_unit_pkg.sv | 14 +
 rtl/lab5_fetch_unit_if.sv | 32 +++
 rtl/lab5_fetch_unit.sv | 97 +++++++++
 tb/tb_lab5_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab5_fetch_unit_pkg.sv
// Shared constants and fetch-state encoding for the lab5 fetch stage.
package lab5_pkg;

  localparam int          LAB5_ADDR_W    = 8;
  localparam int          LAB5_DATA_W    = 16;
  localparam logic [15:0] LAB5_HALT_WORD = 16'h0001;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/lab5_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, IR hand-off to decode, redirect input and status.
interface lab5_fetch_unit_if
  import lab5_pkg::*;
#(
  parameter int ADDR_W = LAB5_ADDR_W,
  parameter int DATA_W = LAB5_DATA_W
);

  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [DATA_W-1:0] IMEM_Q;
  logic [DATA_W-1:0] INSTR;
  logic [ADDR_W-1:0] INSTR_PC;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic              BR_TAKEN;
  logic [ADDR_W-1:0] BR_TARGET;
  logic              HALTED;
  logic [15:0]       FETCH_CNT;

  // The fetch unit itself.
  modport master (
    output IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID, HALTED, FETCH_CNT,
    input  IMEM_Q, INSTR_READY, BR_TAKEN, BR_TARGET
  );

  // ROM, decode and execute seen from the other side.
  modport slave (
    input  IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID, HALTED, FETCH_CNT,
    output IMEM_Q, INSTR_READY, BR_TAKEN, BR_TARGET
  );

endinterface

// File: rtl/lab5_fetch_unit.sv
// Instruction-fetch stage: PC drives the ROM, the returned word lands in the IR and is handed
// to decode over valid/ready; execute may redirect the PC, and a HALT word stops fetching.
module lab5_fetch_unit
  import lab5_pkg::*;
#(
  parameter int                ADDR_W    = LAB5_ADDR_W,
  parameter int                DATA_W    = LAB5_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(LAB5_HALT_WORD)
) (
  input logic               CLK,
  input logic               RESET,
  lab5_fetch_unit_if.master bus
);

  localparam logic [1:0]        S_WAIT     = ST_WAIT;
  localparam logic [1:0]        S_FETCH    = ST_FETCH;
  localparam logic [1:0]        S_HALT     = ST_HALT;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_next_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [ADDR_W-1:0] instr_pc_p1;
  logic              vld_p1;
  logic              halted;
  logic [15:0]       fetch_cnt;
  logic              load_en;

  // A redirect suppresses the load in its cycle; the squashed IR word is simply dropped.
  assign load_en = (state == S_FETCH) && (!vld_p1 || bus.INSTR_READY) && !bus.BR_TAKEN;

  always_comb begin
    pc_next_p0 = pc_p0;
    if (bus.BR_TAKEN) begin
      pc_next_p0 = bus.BR_TARGET & ALIGN_MASK;
    end else if (load_en) begin
      pc_next_p0 = pc_p0 + PC_STEP;
    end
  end

  // p0 -> p1: PC fetch address to instruction register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_WAIT;
      pc_p0       <= RESET_PC & ALIGN_MASK;
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
      vld_p1      <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      pc_p0 <= pc_next_p0;
      if (bus.BR_TAKEN) begin
        vld_p1 <= 1'b0;
        state  <= S_FETCH;
        halted <= 1'b0;
      end else begin
        case (state)
          S_WAIT: state <= S_FETCH;
          S_FETCH: begin
            if (load_en) begin
              instr_p1    <= bus.IMEM_Q;
              instr_pc_p1 <= pc_p0;
              vld_p1      <= 1'b1;
              fetch_cnt   <= sat_inc(fetch_cnt);
              if (bus.IMEM_Q == HALT_WORD) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
            end
          end
          S_HALT: begin
            if (vld_p1 && bus.INSTR_READY) begin
              vld_p1 <= 1'b0;
            end
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.IMEM_ADDR   = pc_p0;
  assign bus.INSTR       = instr_p1;
  assign bus.INSTR_PC    = instr_pc_p1;
  assign bus.INSTR_VALID = vld_p1;
  assign bus.HALTED      = halted;
  assign bus.FETCH_CNT   = fetch_cnt;

endmodule

// File: tb/tb_lab5_fetch_unit.sv
// Bench for lab5_fetch_unit: directed scenarios plus randomized ready/redirect traffic,
// with every accepted instruction checked against a program-order stream model.
module tb_lab5_fetch_unit;
  import lab5_pkg::*;

  localparam logic [15:0] HALT = LAB5_HALT_WORD;

  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  a;
  } exp_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] rom [0:127];
  exp_t        expq[$];
  int          tests = 0;
  int          fails = 0;

  lab5_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  lab5_fetch_unit #(
    .ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .HALT_WORD(16'h0001)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  assign bus.IMEM_Q = rom[bus.IMEM_ADDR[7:1]];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected accept stream: program order from the start address up to and including a HALT.
  function automatic void push_stream(input logic [7:0] start);
    logic [7:0] a;
    a = {start[7:1], 1'b0};
    expq.delete();
    for (int i = 0; i < 128; i++) begin
      expq.push_back(exp_t'({rom[a[7:1]], a}));
      if (rom[a[7:1]] == HALT) break;
      a = a + 8'd2;
    end
  endfunction

  task automatic branch(input logic [7:0] tgt);
    bus.BR_TAKEN  = 1'b1;
    bus.BR_TARGET = tgt;
    @(posedge CLK);
    #1;
    bus.BR_TAKEN = 1'b0;
    push_stream(tgt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instr"},    32'(bus.INSTR),       32'h0);
    chk({tag, "_instr_pc"}, 32'(bus.INSTR_PC),    32'h0);
    chk({tag, "_valid"},    32'(bus.INSTR_VALID), 32'h0);
    chk({tag, "_halted"},   32'(bus.HALTED),      32'h0);
    chk({tag, "_cnt"},      32'(bus.FETCH_CNT),   32'h0);
    chk({tag, "_addr"},     32'(bus.IMEM_ADDR),   32'h0);
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET && bus.INSTR_VALID && bus.INSTR_READY) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got accept at pc %0h required none", bus.INSTR_PC);
      end else begin
        e = expq.pop_front();
        chk("sb_instr",    32'(bus.INSTR),    32'(e.w));
        chk("sb_instr_pc", 32'(bus.INSTR_PC), 32'(e.a));
        chk("sb_halted",   32'(bus.HALTED),   32'(e.w == HALT));
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bus.INSTR_READY = 1'b1;
    bus.BR_TAKEN    = 1'b0;
    bus.BR_TARGET   = 8'h00;
    for (int i = 0; i < 128; i++) rom[i] = 16'hA000 | 16'(i);
    rom[0]  = 16'hF001;
    rom[1]  = 16'h4C12;
    rom[2]  = 16'h7E05;
    rom[29] = HALT;

    #7;
    chk_reset_state("reset");
    #5;
    RESET = 1'b1;
    push_stream(8'h00);

    // T1: one WAIT cycle, then one word per cycle
    @(negedge CLK);
    chk("t1_wait_valid", 32'(bus.INSTR_VALID), 32'h0);
    chk("t1_wait_addr",  32'(bus.IMEM_ADDR),   32'h00);
    @(negedge CLK);
    chk("t1_first_valid", 32'(bus.INSTR_VALID), 32'h1);
    chk("t1_first_instr", 32'(bus.INSTR),       32'hF001);
    chk("t1_first_pc",    32'(bus.INSTR_PC),    32'h00);
    chk("t1_addr2",       32'(bus.IMEM_ADDR),   32'h02);
    @(negedge CLK);
    chk("t1_second_pc", 32'(bus.INSTR_PC),  32'h02);
    chk("t1_addr4",     32'(bus.IMEM_ADDR), 32'h04);

    // T2: stall for three cycles
    @(posedge CLK);
    #1;
    bus.INSTR_READY = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("t2_hold_pc",    32'(bus.INSTR_PC),    32'h04);
      chk("t2_hold_instr", 32'(bus.INSTR),       32'(rom[2]));
      chk("t2_hold_addr",  32'(bus.IMEM_ADDR),   32'h06);
      chk("t2_hold_valid", 32'(bus.INSTR_VALID), 32'h1);
    end
    @(posedge CLK);
    #1;
    bus.INSTR_READY = 1'b1;

    // T4: run into the HALT word at 0x3A
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.HALTED && n < 100);
    chk("t4_halted",    32'(bus.HALTED),      32'h1);
    chk("t4_halt_pc",   32'(bus.INSTR_PC),    32'h3A);
    chk("t4_halt_word", 32'(bus.INSTR),       32'(HALT));
    chk("t4_halt_vld",  32'(bus.INSTR_VALID), 32'h1);
    chk("t4_cnt",       32'(bus.FETCH_CNT),   32'd30);
    repeat (3) @(negedge CLK);
    chk("t4_vld_clear", 32'(bus.INSTR_VALID), 32'h0);
    chk("t4_addr_hold", 32'(bus.IMEM_ADDR),   32'h3C);
    chk("t4_pc_hold",   32'(bus.INSTR_PC),    32'h3A);
    chk("t4_cnt_hold",  32'(bus.FETCH_CNT),   32'd30);
    chk("t4_sb_empty",  32'(expq.size()),     32'h0);

    // T5 (held HALT): redirect leaves HALT
    @(posedge CLK);
    #1;
    branch(8'h10);
    @(negedge CLK);
    chk("t5_unhalt",     32'(bus.HALTED),      32'h0);
    chk("t5_redir_vld",  32'(bus.INSTR_VALID), 32'h0);
    chk("t5_redir_addr", 32'(bus.IMEM_ADDR),   32'h10);
    @(posedge CLK);
    #1;
    chk("t3_pre_valid", 32'(bus.INSTR_VALID), 32'h1);

    // T3: redirect to an odd target while the IR is valid
    branch(8'h29);
    chk("t3_squash", 32'(bus.INSTR_VALID), 32'h0);
    chk("t3_addr",   32'(bus.IMEM_ADDR),   32'h28);
    @(negedge CLK);
    @(negedge CLK);
    chk("t3_valid",  32'(bus.INSTR_VALID), 32'h1);
    chk("t3_pc",     32'(bus.INSTR_PC),    32'h28);

    // T5 (HALT on the load edge): redirect wins over the HALT load
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (bus.IMEM_ADDR != 8'h3A && n < 50);
    chk("t5_reach_3a", 32'(bus.IMEM_ADDR), 32'h3A);
    branch(8'h50);
    chk("t5_no_halt", 32'(bus.HALTED),    32'h0);
    chk("t5_addr50",  32'(bus.IMEM_ADDR), 32'h50);

    // T6: PC wrap from 0xFE
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (bus.IMEM_ADDR != 8'hFE && n < 200);
    chk("t6_reach_fe", 32'(bus.IMEM_ADDR), 32'hFE);
    @(posedge CLK);
    #1;
    chk("t6_wrap", 32'(bus.IMEM_ADDR), 32'h00);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.HALTED && n < 200);
    chk("t6_halted", 32'(bus.HALTED), 32'h1);
    repeat (3) @(negedge CLK);
    chk("t6_sb_empty", 32'(expq.size()), 32'h0);

    // T6: asynchronous reset in the middle of a stall
    @(posedge CLK);
    #1;
    branch(8'h20);
    @(posedge CLK);
    #1;
    bus.INSTR_READY = 1'b0;
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    chk_reset_state("t6_async");
    expq.delete();

    // Randomized ready/redirect traffic over random programs
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) begin
        rom[i] = 16'($urandom);
        if ($urandom_range(0, 15) == 0) rom[i] = HALT;
      end
      rom[$urandom_range(0, 127)] = HALT;
      expq.delete();
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      push_stream(8'h00);
      for (int c = 0; c < 1500; c++) begin
        bus.INSTR_READY = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) begin
          branch(8'($urandom));
        end else begin
          @(posedge CLK);
          #1;
        end
      end
      bus.INSTR_READY = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 300) begin
        @(posedge CLK);
        #1;
        n++;
      end
      repeat (2) @(negedge CLK);
      chk("rnd_sb_empty", 32'(expq.size()),     32'h0);
      chk("rnd_halted",   32'(bus.HALTED),      32'h1);
      chk("rnd_vld_done", 32'(bus.INSTR_VALID), 32'h0);
      RESET = 1'b0;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
